// File: rtl/fetch_mar_mbr_if.sv
// Fetch-stage bus: PC-side request, instruction-memory read handshake and MBR outputs.
// The master side drives the PC/memory inputs; the slave side is the fetch unit.
interface fetch_mar_mbr_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic                     fetch_start;
  logic [ADDR_W-1:0]        pc_addr;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_rd_req;
  logic                     mem_rd_ack;
  logic [DATA_W-1:0]        mem_rd_data;
  logic [DATA_W-1:0]        mbr_data;
  logic [DATA_W-ADDR_W-1:0] ir_opcode;
  logic [ADDR_W-1:0]        mbr2pc;
  logic                     busy;
  logic                     fetch_done;
  logic                     fetch_err;

  modport master (
    output fetch_start, pc_addr, mem_rd_ack, mem_rd_data,
    input  mem_addr, mem_rd_req, mbr_data, ir_opcode, mbr2pc, busy, fetch_done, fetch_err
  );

  modport slave (
    input  fetch_start, pc_addr, mem_rd_ack, mem_rd_data,
    output mem_addr, mem_rd_req, mbr_data, ir_opcode, mbr2pc, busy, fetch_done, fetch_err
  );
endinterface

// File: rtl/fetch_mar_mbr.sv
// Instruction-fetch stage: MAR latch, req/ack memory read, MBR capture, one fetch in flight.
// Optional REQ timeout with sticky fetch_err is built when FETCH_TIMEOUT_EN is defined.
module fetch_mar_mbr #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input logic             clk,
  input logic             rst,
  fetch_mar_mbr_if.slave  bus
);

  // state | meaning
  // IDLE  | waiting for fetch_start; ack ignored
  // REQ   | mem_rd_req high, MAR stable, waiting for ack
  // DONE  | MBR holds the new word, fetch_done pulses this cycle

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mbr_q, mbr_d;
  logic              req_q, req_d;
  logic              done_q, done_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int TMR_W = ($clog2(TIMEOUT_CYC) > 4) ? $clog2(TIMEOUT_CYC) : 4;
  // Down-counter loaded on acceptance; terminal count 0 is the last REQ cycle allowed.
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              err_q, err_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mar_q   <= '0;
      mbr_q   <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tmr_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mbr_q   <= mbr_d;
      req_q   <= req_d;
      done_q  <= done_d;
`ifdef FETCH_TIMEOUT_EN
      tmr_q   <= tmr_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mbr_d   = mbr_q;
    req_d   = req_q;
    done_d  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    tmr_d   = tmr_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.fetch_start) begin
          mar_d   = bus.pc_addr;
          req_d   = 1'b1;
          state_d = ST_REQ;
`ifdef FETCH_TIMEOUT_EN
          tmr_d   = TMR_LOAD;
          err_d   = 1'b0;
`endif
        end
      end
      ST_REQ: begin
        // Ack on the terminal-count edge takes priority over the timeout.
        if (bus.mem_rd_ack) begin
          mbr_d   = bus.mem_rd_data;
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmr_q == '0) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_d   = tmr_q - 1'b1;
        end
`endif
      end
      ST_DONE: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.mem_addr   = mar_q;
  assign bus.mem_rd_req = req_q;
  assign bus.mbr_data   = mbr_q;
  assign bus.ir_opcode  = mbr_q[DATA_W-1:ADDR_W];
  assign bus.mbr2pc     = mbr_q[ADDR_W-1:0];
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.fetch_done = done_q;
`ifdef FETCH_TIMEOUT_EN
  assign bus.fetch_err  = err_q;
`else
  assign bus.fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_mar_mbr.sv
// Randomized self-checking bench for fetch_mar_mbr against a transaction-level model.
// Timeout scenarios run when FETCH_TIMEOUT_EN is defined for the build.
module tb_fetch_mar_mbr;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 15;
`ifdef FETCH_TIMEOUT_EN
  localparam int KMAX = 20;
`else
  localparam int KMAX = 8;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_mar_mbr_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fetch_mar_mbr #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_mbr;
  logic          exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_req"},  32'(bus.mem_rd_req), 32'd0);
    chk({tag, "_done"}, 32'(bus.fetch_done), 32'd0);
    chk({tag, "_mbr"},  32'(bus.mbr_data), 32'(exp_mbr));
    chk({tag, "_opc"},  32'(bus.ir_opcode), 32'(exp_mbr) / 256);
    chk({tag, "_m2pc"}, 32'(bus.mbr2pc), 32'(exp_mbr) % 256);
    chk({tag, "_err"},  32'(bus.fetch_err), 32'(exp_err));
  endtask

  // One fetch: ack arrives k cycles after the accepting edge (if the timeout allows).
  task automatic do_fetch(input logic [AW-1:0] pc, input logic [DW-1:0] data, input int k,
                          input bit ack_at_start, input bit noise);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus.fetch_start = 1'b1;
    bus.pc_addr     = pc;
    bus.mem_rd_ack  = ack_at_start;
    bus.mem_rd_data = DW'($urandom);
    @(posedge clk); #1;
    exp_err = 1'b0;
    chk("acc_req",  32'(bus.mem_rd_req), 32'd1);
    chk("acc_busy", 32'(bus.busy), 32'd1);
    chk("acc_addr", 32'(bus.mem_addr), 32'(pc));
    chk("acc_done", 32'(bus.fetch_done), 32'd0);
    chk("acc_mbr",  32'(bus.mbr_data), 32'(exp_mbr));
    chk("acc_err",  32'(bus.fetch_err), 32'd0);
    for (int c = 1; c <= k; c++) begin
      @(negedge clk);
      bus.mem_rd_ack  = (c == k);
      bus.mem_rd_data = (c == k) ? data : DW'($urandom);
      bus.fetch_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.pc_addr     = noise ? AW'($urandom) : pc;
      @(posedge clk); #1;
      if (c == k) begin
        ok = 1'b1;
        exp_mbr = data;
        chk("cap_done", 32'(bus.fetch_done), 32'd1);
        chk("cap_req",  32'(bus.mem_rd_req), 32'd0);
        chk("cap_busy", 32'(bus.busy), 32'd1);
        chk("cap_mbr",  32'(bus.mbr_data), 32'(exp_mbr));
        chk("cap_opc",  32'(bus.ir_opcode), 32'(exp_mbr) / 256);
        chk("cap_m2pc", 32'(bus.mbr2pc), 32'(exp_mbr) % 256);
        chk("cap_addr", 32'(bus.mem_addr), 32'(pc));
        chk("cap_err",  32'(bus.fetch_err), 32'd0);
      end
`ifdef FETCH_TIMEOUT_EN
      else if (c == TO) begin
        exp_err = 1'b1;
        chk_idle("tmo");
        break;
      end
`endif
      else begin
        chk("wait_req",  32'(bus.mem_rd_req), 32'd1);
        chk("wait_addr", 32'(bus.mem_addr), 32'(pc));
        chk("wait_done", 32'(bus.fetch_done), 32'd0);
        chk("wait_busy", 32'(bus.busy), 32'd1);
        chk("wait_err",  32'(bus.fetch_err), 32'd0);
      end
    end
    @(negedge clk);
    bus.mem_rd_ack  = 1'b0;
    bus.fetch_start = (ok && noise) ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.pc_addr     = AW'($urandom);
    @(posedge clk); #1;
    chk_idle("post");
    @(negedge clk);
    bus.fetch_start = 1'b0;
  endtask

  task automatic idle_ack();
    @(negedge clk);
    bus.fetch_start = 1'b0;
    bus.mem_rd_ack  = 1'b1;
    bus.mem_rd_data = 16'hFFFF;
    @(posedge clk); #1;
    chk_idle("iack");
    @(negedge clk);
    bus.mem_rd_ack = 1'b0;
  endtask

  task automatic rst_mid_fetch(input int m);
    @(negedge clk);
    bus.fetch_start = 1'b1;
    bus.pc_addr     = AW'($urandom);
    bus.mem_rd_ack  = 1'b0;
    repeat (m) begin
      @(negedge clk);
      bus.fetch_start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    exp_mbr = '0;
    exp_err = 1'b0;
    chk_idle("rst");
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_rd_ack  = 1'b1;
    bus.mem_rd_data = DW'($urandom);
    @(posedge clk); #1;
    chk_idle("late_ack");
    @(negedge clk);
    bus.mem_rd_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.fetch_start = 1'b0;
    bus.pc_addr     = '0;
    bus.mem_rd_ack  = 1'b0;
    bus.mem_rd_data = '0;
    exp_mbr = '0;
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    chk("reset_addr", 32'(bus.mem_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_fetch(8'h05, 16'hA30C, 1, 1'b0, 1'b0);
    do_fetch(8'h40, 16'h5A7E, 5, 1'b0, 1'b1);
    idle_ack();
    do_fetch(8'hFF, 16'h1234, 2, 1'b1, 1'b0);
    rst_mid_fetch(2);
`ifdef FETCH_TIMEOUT_EN
    do_fetch(8'h22, 16'hBEEF, 40, 1'b0, 1'b0);
    idle_ack();
    do_fetch(8'h23, 16'hC0DE, TO, 1'b0, 1'b0);
    do_fetch(8'h24, 16'hDEAD, TO + 1, 1'b0, 1'b1);
`else
    do_fetch(8'h22, 16'hBEEF, 30, 1'b0, 1'b1);
`endif

    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 7)
        do_fetch(AW'($urandom), DW'($urandom), $urandom_range(1, KMAX),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else if (sel < 9)
        idle_ack();
      else
        rst_mid_fetch($urandom_range(1, 3));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
